switch_box_cfg: RTL and testbench

- Parametrised, directional-track switch box for the FPGA routing fabric; next generation of the programmable disjoint switch.
- Four sides (l, t, r, b), WIDTH tracks per side; every output track has a 4:1 select (off / three other sides).
- Configuration shifts through the tile's shadow register on the shared prog chain and is applied atomically on prog_commit. Optional Wilton-style track rotation and optional registered outputs for pipelined interconnect.

---
 rtl/switch_box_cfg_if.sv | 37 +++
 rtl/switch_box_cfg.sv | 118 +++++++++++
 tb/tb_switch_box_cfg.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/switch_box_cfg_if.sv
`default_nettype none
// ============================================================================
// Module      : switch_box_cfg_if
// Description : Track bundle of one switch box: four sides of WIDTH-bit
//               incoming values, driven values and per-track drive enables.
// Revision    : 1.0 - initial release
// ============================================================================
interface switch_box_cfg_if #(
    parameter int WIDTH = 3
);
    logic [WIDTH-1:0] l_in;
    logic [WIDTH-1:0] t_in;
    logic [WIDTH-1:0] r_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] l_out;
    logic [WIDTH-1:0] t_out;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] b_out;
    logic [WIDTH-1:0] l_oe;
    logic [WIDTH-1:0] t_oe;
    logic [WIDTH-1:0] r_oe;
    logic [WIDTH-1:0] b_oe;

    // master = surrounding fabric, slave = the switch box
    modport master (
        output l_in, t_in, r_in, b_in,
        input  l_out, t_out, r_out, b_out,
        input  l_oe, t_oe, r_oe, b_oe
    );

    modport slave (
        input  l_in, t_in, r_in, b_in,
        output l_out, t_out, r_out, b_out,
        output l_oe, t_oe, r_oe, b_oe
    );
endinterface
`default_nettype wire

// File: rtl/switch_box_cfg.sv
`default_nettype none
// ============================================================================
// Module      : switch_box_cfg
// Description : Directional-track switch box with shift-chain shadow config,
//               atomic commit, optional track rotation and registered outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_box_cfg #(
    parameter int WIDTH   = 3,
    parameter int PATTERN = 0,
    parameter int REG_OUT = 0
) (
    input  wire             prog_clk,
    input  wire             prog_rst,
    input  wire             prog_in,
    input  wire             prog_en,
    input  wire             prog_commit,
    output logic            prog_out,
    output logic            cfg_valid,
    switch_box_cfg_if.slave trk
);

    localparam int NUM_MUX  = 4 * WIDTH;
    localparam int NUM_BITS = 2 * NUM_MUX;

    logic [NUM_BITS-1:0] sh_q;
    logic [NUM_BITS-1:0] sh_d;
    logic [NUM_BITS-1:0] act_q;
    logic [NUM_BITS-1:0] act_d;
    logic                cfg_valid_q;
    logic                cfg_valid_d;

    logic [WIDTH-1:0]    w_side_in [4];
    logic [NUM_MUX-1:0]  w_mux;
    logic [NUM_MUX-1:0]  w_oe;
    logic [NUM_MUX-1:0]  w_out;

    // Commit captures the shadow as it stood before this edge's shift.
    always_comb begin
        sh_d        = sh_q;
        act_d       = act_q;
        cfg_valid_d = cfg_valid_q;
        if (prog_en) begin
            sh_d = {sh_q[NUM_BITS-2:0], prog_in};
        end
        if (prog_commit) begin
            act_d       = sh_q;
            cfg_valid_d = 1'b1;
        end
    end

    always_ff @(posedge prog_clk or posedge prog_rst) begin
        if (prog_rst) begin
            sh_q        <= '0;
            act_q       <= '0;
            cfg_valid_q <= 1'b0;
        end else begin
            sh_q        <= sh_d;
            act_q       <= act_d;
            cfg_valid_q <= cfg_valid_d;
        end
    end

    assign prog_out  = sh_q[NUM_BITS-1];
    assign cfg_valid = cfg_valid_q;

    assign w_side_in[0] = trk.l_in;
    assign w_side_in[1] = trk.t_in;
    assign w_side_in[2] = trk.r_in;
    assign w_side_in[3] = trk.b_in;

    // Select 1/2/3 = next clockwise / opposite / previous side, i.e. side+sel mod 4.
    for (genvar s = 0; s < 4; s++) begin : g_side
        for (genvar i = 0; i < WIDTH; i++) begin : g_trk
            localparam int K     = s * WIDTH + i;
            localparam int S_CW  = (s + 1) % 4;
            localparam int S_OPP = (s + 2) % 4;
            localparam int S_CCW = (s + 3) % 4;
            localparam int I_CW  = (PATTERN == 1) ? (i + 1) % WIDTH : i;
            localparam int I_CCW = (PATTERN == 1) ? (i + WIDTH - 1) % WIDTH : i;

            logic [1:0] w_sel;
            assign w_sel = act_q[2*K +: 2];

            assign w_mux[K] = !cfg_valid_q   ? 1'b0 :
                              (w_sel == 2'd1) ? w_side_in[S_CW][I_CW] :
                              (w_sel == 2'd2) ? w_side_in[S_OPP][i] :
                              (w_sel == 2'd3) ? w_side_in[S_CCW][I_CCW] :
                                                1'b0;
            assign w_oe[K]  = cfg_valid_q & (w_sel != 2'd0);
        end
    end

    if (REG_OUT != 0) begin : g_reg_out
        logic [NUM_MUX-1:0] out_q;
        always_ff @(posedge prog_clk or posedge prog_rst) begin
            if (prog_rst) begin
                out_q <= '0;
            end else begin
                out_q <= w_mux;
            end
        end
        assign w_out = out_q;
    end else begin : g_comb_out
        assign w_out = w_mux;
    end

    assign trk.l_out = w_out[0*WIDTH +: WIDTH];
    assign trk.t_out = w_out[1*WIDTH +: WIDTH];
    assign trk.r_out = w_out[2*WIDTH +: WIDTH];
    assign trk.b_out = w_out[3*WIDTH +: WIDTH];
    assign trk.l_oe  = w_oe[0*WIDTH +: WIDTH];
    assign trk.t_oe  = w_oe[1*WIDTH +: WIDTH];
    assign trk.r_oe  = w_oe[2*WIDTH +: WIDTH];
    assign trk.b_oe  = w_oe[3*WIDTH +: WIDTH];

endmodule
`default_nettype wire

// File: tb/tb_switch_box_cfg.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_box_cfg
// Description : Bench for switch_box_cfg; three variants (disjoint, rotated,
//               registered) share the prog chain and track inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_box_cfg;

    localparam int W  = 3;
    localparam int NM = 4 * W;
    localparam int NB = 2 * NM;

    logic clk = 1'b0;
    logic rst;
    logic prog_in, prog_en, prog_commit;
    logic [W-1:0] l_in, t_in, r_in, b_in;
    logic po0, po1, po2, cv0, cv1, cv2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    switch_box_cfg_if #(.WIDTH(W)) if0 ();
    switch_box_cfg_if #(.WIDTH(W)) if1 ();
    switch_box_cfg_if #(.WIDTH(W)) if2 ();

    assign if0.l_in = l_in; assign if0.t_in = t_in; assign if0.r_in = r_in; assign if0.b_in = b_in;
    assign if1.l_in = l_in; assign if1.t_in = t_in; assign if1.r_in = r_in; assign if1.b_in = b_in;
    assign if2.l_in = l_in; assign if2.t_in = t_in; assign if2.r_in = r_in; assign if2.b_in = b_in;

    switch_box_cfg #(.WIDTH(W), .PATTERN(0), .REG_OUT(0)) d0 (
        .prog_clk(clk), .prog_rst(rst), .prog_in(prog_in), .prog_en(prog_en),
        .prog_commit(prog_commit), .prog_out(po0), .cfg_valid(cv0), .trk(if0.slave));
    switch_box_cfg #(.WIDTH(W), .PATTERN(1), .REG_OUT(0)) d1 (
        .prog_clk(clk), .prog_rst(rst), .prog_in(prog_in), .prog_en(prog_en),
        .prog_commit(prog_commit), .prog_out(po1), .cfg_valid(cv1), .trk(if1.slave));
    switch_box_cfg #(.WIDTH(W), .PATTERN(0), .REG_OUT(1)) d2 (
        .prog_clk(clk), .prog_rst(rst), .prog_in(prog_in), .prog_en(prog_en),
        .prog_commit(prog_commit), .prog_out(po2), .cfg_valid(cv2), .trk(if2.slave));

    logic [NM-1:0] out0, out1, out2, oe0, oe1, oe2;
    logic [NM-1:0] in_flat;
    assign out0 = {if0.b_out, if0.r_out, if0.t_out, if0.l_out};
    assign out1 = {if1.b_out, if1.r_out, if1.t_out, if1.l_out};
    assign out2 = {if2.b_out, if2.r_out, if2.t_out, if2.l_out};
    assign oe0  = {if0.b_oe, if0.r_oe, if0.t_oe, if0.l_oe};
    assign oe1  = {if1.b_oe, if1.r_oe, if1.t_oe, if1.l_oe};
    assign oe2  = {if2.b_oe, if2.r_oe, if2.t_oe, if2.l_oe};
    assign in_flat = {b_in, r_in, t_in, l_in};

    // Reference: output track k on side k/W, track k%W; sel from act bits 2k+1:2k.
    function automatic logic model_bit(input int pat, input int k, input logic [NB-1:0] act,
                                       input logic valid, input logic [NM-1:0] inf);
        int side, i, sel, src, t;
        side = k / W;
        i    = k % W;
        sel  = {30'd0, act[2*k+1], act[2*k]};
        if (!valid || sel == 0) return 1'b0;
        case (side)
            0:       src = (sel == 1) ? 1 : (sel == 2) ? 2 : 3;
            1:       src = (sel == 1) ? 2 : (sel == 2) ? 3 : 0;
            2:       src = (sel == 1) ? 3 : (sel == 2) ? 0 : 1;
            default: src = (sel == 1) ? 0 : (sel == 2) ? 1 : 2;
        endcase
        if (pat == 0 || sel == 2) t = i;
        else if (sel == 1)        t = (i + 1) % W;
        else                      t = (i + W - 1) % W;
        return inf[src*W + t];
    endfunction

    logic [NB-1:0] m_sh, m_act;
    logic          m_valid;
    logic [NM-1:0] m_reg;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_sh    <= '0;
            m_act   <= '0;
            m_valid <= 1'b0;
            m_reg   <= '0;
        end else begin
            for (int k = 0; k < NM; k++)
                m_reg[k] <= model_bit(0, k, m_act, m_valid, in_flat);
            if (prog_commit) begin
                m_act   <= m_sh;
                m_valid <= 1'b1;
            end
            if (prog_en) m_sh <= {m_sh[NB-2:0], prog_in};
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    logic [NM-1:0] e0, e1, eoe;
    always @(negedge clk) begin
        for (int k = 0; k < NM; k++) begin
            e0[k]  = model_bit(0, k, m_act, m_valid, in_flat);
            e1[k]  = model_bit(1, k, m_act, m_valid, in_flat);
            eoe[k] = m_valid && ({m_act[2*k+1], m_act[2*k]} != 2'b00);
        end
        chk("cyc_out_disjoint", 64'(out0), 64'(e0));
        chk("cyc_out_rotated",  64'(out1), 64'(e1));
        chk("cyc_out_reg",      64'(out2), 64'(m_reg));
        chk("cyc_oe",           64'({oe0, oe1, oe2}), 64'({eoe, eoe, eoe}));
        chk("cyc_prog_valid",   64'({po0, po1, po2, cv0, cv1, cv2}),
                                64'({{3{m_sh[NB-1]}}, {3{m_valid}}}));
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic shift_word(input logic [NB-1:0] v);
        for (int b = NB - 1; b >= 0; b--) begin
            step();
            prog_in = v[b];
            prog_en = 1'b1;
        end
        step();
        prog_en = 1'b0;
    endtask

    task automatic commit();
        prog_commit = 1'b1;
        step();
        prog_commit = 1'b0;
    endtask

    logic [47:0] chain_bits;
    logic [NM-1:0] exp_oe;

    initial begin
        rst = 1'b1;
        prog_in = 1'b0; prog_en = 1'b0; prog_commit = 1'b0;
        l_in = '0; t_in = '0; r_in = '0; b_in = '0;
        step(); step();
        rst = 1'b0;
        chk("reset_state", 64'({po0, cv0, oe0, out0, out1, out2}), 64'd0);

        // Single route: l track 0 takes t
        shift_word(24'h000001);
        commit();
        chk("first_commit_valid", 64'(cv0), 64'd1);
        chk("first_commit_l_oe",  64'(if0.l_oe), 64'd1);
        chk("first_commit_oth_oe", 64'({if0.t_oe, if0.r_oe, if0.b_oe}), 64'd0);
        t_in = 3'b001; #1;
        chk("l_out0_t1", 64'(if0.l_out), 64'd1);
        t_in = 3'b000; #1;
        chk("l_out0_t0", 64'(if0.l_out), 64'd0);
        t_in = 3'b010; #1;
        chk("rot_l_out0_from_t1", 64'(if1.l_out), 64'd1);
        chk("disj_l_out0_not_t1", 64'(if0.l_out), 64'd0);
        chk("pin_model_rot", 64'(model_bit(1, 0, m_act, m_valid, in_flat)), 64'd1);

        // Everything routed, then reset in the middle of a shift
        shift_word(24'hFFFFFF);
        commit();
        l_in = '1; t_in = '1; r_in = '1; b_in = '1;
        step(); step();
        chk("pre_reset_reg_out", 64'(out2), 64'hFFF);
        prog_in = 1'b1; prog_en = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("async_reset", 64'({po0, cv0, cv1, cv2, oe0, oe1, oe2, out0, out1, out2}), 64'd0);
        step();
        rst = 1'b0; prog_en = 1'b0;

        // 48-bit chain pass-through
        chain_bits = {16'($urandom), 32'($urandom)};
        for (int c = 0; c < 48; c++) begin
            step();
            if (c >= 24) chk("chain_prog_out", 64'(po0), 64'(chain_bits[c-24]));
            prog_in = chain_bits[c];
            prog_en = 1'b1;
        end
        step();
        chk("chain_prog_out_last", 64'(po0), 64'(chain_bits[24]));
        chk("chain_no_commit_oe", 64'({oe0, cv0}), 64'd0);

        // Commit and shift on the same edge
        prog_commit = 1'b1; prog_en = 1'b1; prog_in = 1'b0;
        step();
        prog_commit = 1'b0; prog_en = 1'b0;
        for (int k = 0; k < NM; k++)
            exp_oe[k] = chain_bits[47-2*k] | chain_bits[47-(2*k+1)];
        chk("commit_en_oe", 64'(oe0), 64'(exp_oe));
        chk("commit_en_shifted", 64'(po0), 64'(chain_bits[25]));

        // Rotated: b0 sel3 (from r, track 2), t2 sel1 (from r, track 0)
        shift_word(24'h0C0400);
        commit();
        for (int n = 0; n < 6; n++) begin
            r_in = 3'($urandom_range(0, 7));
            l_in = 3'($urandom_range(0, 7));
            #1;
            chk("rot_b0_from_r2", 64'(if1.b_out[0]), 64'(r_in[2]));
            chk("rot_t2_from_r0", 64'(if1.t_out[2]), 64'(r_in[0]));
            step();
        end

        // Registered straight l -> r on track 1
        shift_word(24'h008000);
        commit();
        l_in = '0;
        step(); step();
        l_in[1] = 1'b1;
        #1;
        chk("reg_r1_before_edge", 64'(if2.r_out[1]), 64'd0);
        chk("comb_r1_immediate",  64'(if0.r_out[1]), 64'd1);
        @(posedge clk);
        #1;
        chk("reg_r1_after_edge", 64'(if2.r_out[1]), 64'd1);

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            step();
            rst         = ($urandom_range(0, 59) == 0);
            prog_en     = 1'($urandom);
            prog_in     = 1'($urandom);
            prog_commit = ($urandom_range(0, 7) == 0);
            l_in = 3'($urandom_range(0, 7));
            t_in = 3'($urandom_range(0, 7));
            r_in = 3'($urandom_range(0, 7));
            b_in = 3'($urandom_range(0, 7));
        end
        step();
        rst = 1'b0; prog_en = 1'b0; prog_commit = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
